wr_mem_arbiter: RTL and testbench
=================================

WR_MEM_ARBITER -- requirements
Module: wr_mem_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, meaning the number of write requesters (2..16).
REQ-002 SHALL have parameter DataWidth, default 32, meaning the write data width.
REQ-003 SHALL have parameter AddrWidth, default 32, meaning the memory address width.
REQ-004 SHALL have parameter BurstLen, default 4, meaning the maximum beats per grant (>=1).
REQ-005 SHALL have one clock and a synchronous active-low reset: clk_i and rst_ni.
REQ-006 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_ni  input  1  synchronous active-low reset.
REQ-008 SHALL have port cfg_base_addr_i  input  NumReq x AddrWidth  per-requester base address.
REQ-009 SHALL have port cfg_load_i  input  NumReq  per-requester load of its address pointer from its base.
REQ-010 SHALL have port req_data_i  input  NumReq x DataWidth  requester write data.
REQ-011 SHALL have port req_valid_i  input  NumReq  requester write valid.
REQ-012 SHALL have port req_ready_o  output  NumReq  requester write ready.
REQ-013 SHALL have port mem_addr_o  output  AddrWidth  memory write address.
REQ-014 SHALL have port mem_data_o  output  DataWidth  memory write data.
REQ-015 SHALL have port mem_valid_o  output  1  memory write valid.
REQ-016 SHALL have port mem_ready_i  input  1  memory write ready.
REQ-017 SHALL have port grant_o  output  NumReq  one-hot current grant; all zero when idle.
REQ-018 SHALL have port busy_o  output  1  high while in BURST state.

Function
REQ-019 SHALL implement a two-state FSM: IDLE and BURST.
REQ-020 In IDLE, if any req_valid_i is set, SHALL latch the winner into grant_o and enter BURST on the next cycle; otherwise stay IDLE.
REQ-021 Winner selection SHALL be round-robin: the first set req_valid_i, searching upward from rr_ptr and wrapping at NumReq.
REQ-022 In IDLE, mem_valid_o and all req_ready_o SHALL be 0; no beat transfers in the arbitration cycle.
REQ-023 In BURST with grantee g, mem_valid_o = req_valid_i[g], mem_data_o = req_data_i[g], mem_addr_o = ptr[g], req_ready_o[g] = mem_ready_i, and all other req_ready_o = 0 (combinational, zero latency).
REQ-024 A beat SHALL occur when mem_valid_o and mem_ready_i are both high; each beat increments ptr[g] by 1 (modulo 2^AddrWidth) and the beat counter by 1.
REQ-025 BURST SHALL end, returning to IDLE next cycle, on (a) the beat that makes the count equal BurstLen, or (b) any cycle where req_valid_i[g] = 0.
REQ-026 On burst end, SHALL clear grant_o and the beat counter, and set rr_ptr = (g+1) mod NumReq.
REQ-027 A stall (mem_valid_o=1, mem_ready_i=0) SHALL hold all state; the grant SHALL NOT be lost.
REQ-028 cfg_load_i[k] SHALL set ptr[k] = cfg_base_addr_i[k] next cycle; if it coincides with a beat of requester k, the load wins and the increment is discarded.
REQ-029 Pointers of non-granted requesters SHALL change only through cfg_load_i.
REQ-030 The beat counter SHALL be clog2(BurstLen+1) bits wide and never exceed BurstLen.
REQ-031 grant_o SHALL always be one-hot or zero; busy_o = (state == BURST).

Reset
REQ-032 With rst_ni low at a rising edge: state=IDLE, grant_o=0, busy_o=0, rr_ptr=0, beat counter=0, all ptr=0; hence mem_valid_o=0 and req_ready_o=0.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no beat counted in that cycle; resumption requires cfg_load_i.

Verification
REQ-034 Single requester: load base 0x100 on req 0, req 0 valid for 6 beats, mem_ready_i=1 -> beats at 0x100..0x103, 1 idle cycle, then 0x104, 0x105; ptr[0]=0x106.
REQ-035 Round-robin: reqs 0 and 2 continuously valid, BurstLen=4 -> grants alternate 0,2,0,2 with 4 beats each and 1 IDLE cycle between.
REQ-036 Backpressure: mem_ready_i low for 3 cycles mid-burst -> mem_addr_o/mem_data_o held stable, grant kept, total beats still 4.
REQ-037 Early release: req 1 drops valid after 2 beats -> IDLE next cycle, rr_ptr=2, ptr[1]=base+2.
REQ-038 Load collision: cfg_load_i[0] with base 0x40 coinciding with a req 0 beat -> ptr[0]=0x40 next cycle.
REQ-039 Wrap: ptr = 2^AddrWidth-1, one beat -> ptr wraps to 0; reset mid-burst -> all outputs zero next cycle.

Source files
------------

// File: rtl/wr_mem_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to BurstLen
// beats into memory, each requester writing through its own auto-incrementing pointer.
module wr_mem_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int BurstLen  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq*AddrWidth-1:0] cfg_base_addr_i,
    input  logic [NumReq-1:0]           cfg_load_i,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic [AddrWidth-1:0]        mem_addr_o,
    output logic [DataWidth-1:0]        mem_data_o,
    output logic                        mem_valid_o,
    input  logic                        mem_ready_i,
    output logic [NumReq-1:0]           grant_o,
    output logic                        busy_o
);
    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(BurstLen + 1);

    typedef enum logic {IDLE, BURST} state_e;

    state_e               state_q, state_d;
    logic [NumReq-1:0]    grant_q, grant_d;
    logic [IdxW-1:0]      gidx_q, gidx_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [AddrWidth-1:0] ptr_q [NumReq];
    logic [AddrWidth-1:0] ptr_d [NumReq];
    logic [AddrWidth-1:0] base_arr [NumReq];
    logic [DataWidth-1:0] data_arr [NumReq];
    logic                 beat;
    logic                 found;
    logic [IdxW-1:0]      cand;

    for (genvar k = 0; k < NumReq; k++) begin : g_unpack
        assign base_arr[k] = cfg_base_addr_i[k*AddrWidth +: AddrWidth];
        assign data_arr[k] = req_data_i[k*DataWidth +: DataWidth];
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        busy_o      = (state_q == BURST);
        grant_o     = grant_q;
        mem_valid_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        req_ready_o = '0;
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        found       = 1'b0;
        cand        = '0;

        if (state_q == BURST) begin
            mem_valid_o = req_valid_i[gidx_q];
            mem_addr_o  = ptr_q[gidx_q];
            mem_data_o  = data_arr[gidx_q];
            req_ready_o = grant_q & {NumReq{mem_ready_i}};
        end
        beat = mem_valid_o & mem_ready_i;

        case (state_q)
            IDLE: begin
                // Search upward from rr_ptr_q, wrapping, for the first valid requester.
                for (int i = 0; i < NumReq; i++) begin
                    cand = IdxW'((int'(rr_ptr_q) + i) % NumReq);
                    if (!found && req_valid_i[cand]) begin
                        found   = 1'b1;
                        gidx_d  = cand;
                        grant_d = NumReq'(1) << cand;
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                if (beat) begin
                    ptr_d[gidx_q] = ptr_q[gidx_q] + AddrWidth'(1);
                end
                if (!req_valid_i[gidx_q] || (beat && cnt_q == CntW'(BurstLen - 1))) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    cnt_d    = '0;
                    rr_ptr_d = IdxW'((int'(gidx_q) + 1) % NumReq);
                end else if (beat) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A load overrides any increment from a coinciding beat.
        for (int k = 0; k < NumReq; k++) begin
            if (cfg_load_i[k]) begin
                ptr_d[k] = base_arr[k];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the pointer array is reset too, since software relies on pointers starting at zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int k = 0; k < NumReq; k++) begin
                ptr_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

endmodule

// File: tb/tb_wr_mem_arbiter.sv
// Bench for wr_mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run, all compared against a behavioural model of the arbitration rules.
module tb_wr_mem_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BL = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [N*AW-1:0] cfg_base_addr_i;
    logic [N-1:0]    cfg_load_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_data_o;
    logic            mem_valid_o;
    logic            mem_ready_i;
    logic [N-1:0]    grant_o;
    logic            busy_o;

    wr_mem_arbiter #(.NumReq(N), .DataWidth(DW), .AddrWidth(AW), .BurstLen(BL)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_base_addr_i(cfg_base_addr_i),
        .cfg_load_i(cfg_load_i), .req_data_i(req_data_i), .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .grant_o(grant_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: who owns the bus, how many beats it has had, whose turn is next.
    bit            m_busy = 1'b0;
    int            m_g    = 0;
    int            m_cnt  = 0;
    int            m_rr   = 0;
    logic [AW-1:0] m_ptr [N];

    typedef struct {
        logic          load0;
        logic [N-1:0]  valid;
        logic          ready;
        logic          busy;
        logic [N-1:0]  grant;
        logic          mv;
        logic [AW-1:0] addr;
    } vec_t;
    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(logic ld, logic [N-1:0] v, logic r, logic b,
                                logic [N-1:0] g, logic mv, logic [AW-1:0] a);
        vec_t t;
        t.load0 = ld; t.valid = v; t.ready = r; t.busy = b; t.grant = g; t.mv = mv; t.addr = a;
        return t;
    endfunction

    task automatic set_base(input int k, input logic [AW-1:0] v);
        cfg_base_addr_i[k*AW +: AW] = v;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rdy, input logic [N-1:0] ld);
        req_valid_i = v;
        mem_ready_i = rdy;
        cfg_load_i  = ld;
    endtask

    task automatic model_check();
        logic [N-1:0] eg;
        if (!chk_en) return;
        eg = m_busy ? (N'(1) << m_g) : '0;
        check("m_busy",  64'(busy_o),      64'(m_busy));
        check("m_grant", 64'(grant_o),     64'(eg));
        check("m_valid", 64'(mem_valid_o), 64'(m_busy && req_valid_i[m_g]));
        check("m_addr",  64'(mem_addr_o),  64'(m_busy ? m_ptr[m_g] : '0));
        check("m_data",  64'(mem_data_o),  64'(m_busy ? req_data_i[m_g*DW +: DW] : '0));
        check("m_ready", 64'(req_ready_o), 64'((m_busy && mem_ready_i) ? eg : '0));
    endtask

    task automatic model_update();
        logic [AW-1:0] nptr [N];
        bit beat;
        if (!rst_ni) begin
            m_busy = 1'b0; m_g = 0; m_cnt = 0; m_rr = 0;
            foreach (m_ptr[k]) m_ptr[k] = '0;
            return;
        end
        nptr = m_ptr;
        if (m_busy) begin
            beat = req_valid_i[m_g] && mem_ready_i;
            if (beat) nptr[m_g] = m_ptr[m_g] + 1;
            if (!req_valid_i[m_g] || (beat && m_cnt + 1 == BL)) begin
                m_busy = 1'b0; m_cnt = 0; m_rr = (m_g + 1) % N;
            end else if (beat) begin
                m_cnt++;
            end
        end else if (req_valid_i != '0) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid_i[(m_rr + i) % N]) begin
                    m_g = (m_rr + i) % N;
                    break;
                end
            end
            m_busy = 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            if (cfg_load_i[k]) nptr[k] = cfg_base_addr_i[k*AW +: AW];
        end
        m_ptr = nptr;
    endtask

    task automatic tick();
        #1;
        model_check();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        drive('0, 1'b0, '0);
        tick();
        rst_ni = 1'b1;
        check("rst_busy",  64'(busy_o),      64'(0));
        check("rst_grant", 64'(grant_o),     64'(0));
        check("rst_valid", 64'(mem_valid_o), 64'(0));
        check("rst_ready", 64'(req_ready_o), 64'(0));
        check("rst_addr",  64'(mem_addr_o),  64'(0));
    endtask

    initial begin
        int cyc;
        int beats;
        logic [N-1:0] eg;

        foreach (m_ptr[k]) m_ptr[k] = '0;
        rst_ni = 1'b0;
        cfg_base_addr_i = '0;
        req_data_i = '0;
        drive('0, 1'b0, '0);
        repeat (2) @(negedge clk_i);
        chk_en = 1'b1;
        do_reset();

        // Single requester: 4-beat burst, idle cycle, then early release after 2 more beats.
        tbl[0]  = mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 32'h100);
        tbl[3]  = mk(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 32'h101);
        tbl[4]  = mk(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 32'h102);
        tbl[5]  = mk(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 32'h103);
        tbl[6]  = mk(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0);
        tbl[7]  = mk(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 32'h104);
        tbl[8]  = mk(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 32'h105);
        tbl[9]  = mk(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0, 32'h106);
        tbl[10] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0);
        tbl[11] = mk(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0);
        tbl[12] = mk(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 32'h106);
        tbl[13] = mk(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0, 32'h107);
        tbl[14] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0);

        set_base(0, 32'h100);
        for (int k = 0; k < N; k++) req_data_i[k*DW +: DW] = 32'hD000_0000 + 32'(k);
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].valid, tbl[i].ready, {3'b000, tbl[i].load0});
            #1;
            check($sformatf("tbl%0d_busy", i),  64'(busy_o),      64'(tbl[i].busy));
            check($sformatf("tbl%0d_grant", i), 64'(grant_o),     64'(tbl[i].grant));
            check($sformatf("tbl%0d_valid", i), 64'(mem_valid_o), 64'(tbl[i].mv));
            check($sformatf("tbl%0d_addr", i),  64'(mem_addr_o),  64'(tbl[i].addr));
            tick();
        end

        // Round robin between requesters 0 and 2.
        do_reset();
        drive(4'b0101, 1'b1, '0);
        beats = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (c % 5 == 0) eg = 4'b0000;
            else eg = ((c / 5) % 2 == 0) ? 4'b0001 : 4'b0100;
            check($sformatf("rr_grant%0d", c), 64'(grant_o), 64'(eg));
            if (mem_valid_o && mem_ready_i) beats++;
            tick();
        end
        check("rr_beats", 64'(beats), 64'(12));

        // Backpressure: three stalled cycles after the first beat.
        do_reset();
        set_base(1, 32'h300);
        drive('0, 1'b1, 4'b0010);
        tick();
        drive(4'b0010, 1'b1, '0);
        tick();
        cyc = 0;
        beats = 0;
        while (cyc < 12) begin
            drive(4'b0010, !(cyc >= 1 && cyc <= 3), '0);
            #1;
            if (!busy_o) break;
            if (mem_valid_o && mem_ready_i) beats++;
            if (cyc >= 1 && cyc <= 3) begin
                check("bp_addr",  64'(mem_addr_o), 64'(32'h301));
                check("bp_grant", 64'(grant_o),    64'(4'b0010));
                check("bp_data",  64'(mem_data_o), 64'(32'hD000_0001));
            end
            tick();
            cyc++;
        end
        check("bp_beats", 64'(beats), 64'(4));
        check("bp_len",   64'(cyc),   64'(7));

        // Early release: requester 1 drops valid after two beats.
        do_reset();
        set_base(1, 32'h200);
        drive('0, 1'b1, 4'b0010);
        tick();
        drive(4'b0010, 1'b1, '0);
        tick();
        tick();
        tick();
        drive('0, 1'b1, '0);
        tick();
        #1;
        check("er_idle", 64'(busy_o), 64'(0));
        drive(4'b0110, 1'b1, '0);
        tick();
        #1;
        check("er_rr", 64'(grant_o), 64'(4'b0100));
        drive('0, 1'b1, '0);
        tick();
        drive(4'b0010, 1'b1, '0);
        tick();
        #1;
        check("er_ptr", 64'(mem_addr_o), 64'(32'h202));
        drive('0, 1'b1, '0);
        tick();
        tick();

        // Load colliding with a beat of the same requester.
        do_reset();
        set_base(0, 32'h100);
        drive('0, 1'b1, 4'b0001);
        tick();
        drive(4'b0001, 1'b1, '0);
        tick();
        tick();
        set_base(0, 32'h40);
        drive(4'b0001, 1'b1, 4'b0001);
        #1;
        check("ld_before", 64'(mem_addr_o), 64'(32'h101));
        tick();
        drive(4'b0001, 1'b1, '0);
        #1;
        check("ld_addr", 64'(mem_addr_o), 64'(32'h40));
        check("ld_busy", 64'(busy_o),     64'(1));
        tick();
        drive('0, 1'b1, '0);
        tick();
        tick();

        // Pointer wrap, then reset in the middle of a burst.
        do_reset();
        set_base(3, {AW{1'b1}});
        drive('0, 1'b1, 4'b1000);
        tick();
        drive(4'b1000, 1'b1, '0);
        tick();
        #1;
        check("wr_top", 64'(mem_addr_o), 64'(32'hFFFF_FFFF));
        tick();
        drive('0, 1'b1, '0);
        tick();
        drive(4'b1000, 1'b1, '0);
        tick();
        #1;
        check("wr_zero", 64'(mem_addr_o), 64'(0));
        check("wr_busy", 64'(busy_o),     64'(1));
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        #1;
        check("mr_busy",  64'(busy_o),      64'(0));
        check("mr_grant", 64'(grant_o),     64'(0));
        check("mr_valid", 64'(mem_valid_o), 64'(0));
        check("mr_ready", 64'(req_ready_o), 64'(0));
        check("mr_addr",  64'(mem_addr_o),  64'(0));
        check("mr_data",  64'(mem_data_o),  64'(0));
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            logic [N-1:0] v;
            logic [N-1:0] ld;
            for (int k = 0; k < N; k++) begin
                v[k]  = ($urandom_range(3) != 0);
                ld[k] = ($urandom_range(15) == 0);
                req_data_i[k*DW +: DW] = $urandom();
                if ($urandom_range(7) == 0)
                    set_base(k, ($urandom_range(3) == 0) ? {AW{1'b1}} : AW'($urandom()));
            end
            rst_ni = ($urandom_range(199) != 0);
            drive(v, ($urandom_range(3) != 0), ld);
            tick();
        end
        rst_ni = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
